// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - keypad counter game sequencer: screen flow, selection, cursor, status digits
// Edge-detects the keypad vector and applies at most one action per clock edge.
module game_ctrl #(
  parameter int         MAX_SEL    = 4,
  parameter logic [3:0] INIT_DIGIT = 4'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] btn,
  output logic [1:0]  state,
  output logic [2:0]  sel_num,
  output logic [3:0]  cursor,
  output logic [39:0] status,
  output logic [9:0]  buzz_req,
  output logic [7:0]  moves,
  output logic        win
);

  typedef enum logic [1:0] {
    ST_MENU   = 2'd0,
    ST_INFO   = 2'd1,
    ST_SELECT = 2'd2,
    ST_GAME   = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_btn_q;
  logic [2:0]  r_sel, w_sel_nxt;
  logic [3:0]  r_cursor, w_cursor_nxt;
  logic [39:0] r_status, w_status_nxt;
  logic [9:0]  r_buzz, w_buzz_nxt;
  logic [7:0]  r_moves, w_moves_nxt;
  logic        r_win, w_win_nxt;

  logic [15:0] w_press;
  logic [9:0]  w_hit;
  logic        w_row;
  logic [3:0]  w_col;

  assign w_press = btn & ~r_btn_q;
  assign w_row   = (r_cursor >= 4'd5);
  assign w_col   = w_row ? (r_cursor - 4'd5) : r_cursor;

  // Digits touched by a confirm: sel_num consecutive indices from the cursor, modulo 10.
  always_comb begin
    logic [4:0] idx;
    idx   = '0;
    w_hit = '0;
    for (int k = 0; k < MAX_SEL; k++) begin
      if (3'(k) < r_sel) begin
        idx = {1'b0, r_cursor} + 5'(k);
        if (idx >= 5'd10) idx = idx - 5'd10;
        w_hit[idx[3:0]] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_cursor_nxt = r_cursor;
    w_status_nxt = r_status;
    w_buzz_nxt   = '0;
    w_moves_nxt  = r_moves;

    case (r_state)
      ST_MENU: begin
        if (w_press[14])      w_state_nxt = ST_SELECT;
        else if (w_press[15]) w_state_nxt = ST_INFO;
      end
      ST_INFO: begin
        if (w_press[14])      w_state_nxt = ST_SELECT;
        else if (w_press[13]) w_state_nxt = ST_MENU;
      end
      ST_SELECT: begin
        if (w_press[12]) begin
          w_state_nxt = ST_MENU;
        end else if (w_press[14]) begin
          w_state_nxt  = ST_GAME;
          w_status_nxt = {10{INIT_DIGIT}};
          w_cursor_nxt = 4'd0;
          w_moves_nxt  = 8'd0;
        end else if (w_press[11]) begin
          w_sel_nxt = (r_sel == 3'(MAX_SEL)) ? 3'd1 : r_sel + 3'd1;
        end
      end
      ST_GAME: begin
        if (w_press[12]) begin
          w_state_nxt = ST_MENU;
        end else if (!r_win) begin
          if (w_press[10]) begin
            for (int i = 0; i < 10; i++) begin
              if (w_hit[i]) begin
                if (r_status[4*i +: 4] == 4'd9) begin
                  w_status_nxt[4*i +: 4] = 4'd0;
                  w_buzz_nxt[i]          = 1'b1;
                end else begin
                  w_status_nxt[4*i +: 4] = r_status[4*i +: 4] + 4'd1;
                end
              end
            end
            if (r_moves != 8'hFF) w_moves_nxt = r_moves + 8'd1;
          end else if (w_press[2] || w_press[6]) begin
            w_cursor_nxt = w_row ? (r_cursor - 4'd5) : (r_cursor + 4'd5);
          end else if (w_press[7]) begin
            w_cursor_nxt = (w_col == 4'd0) ? (r_cursor + 4'd4) : (r_cursor - 4'd1);
          end else if (w_press[5]) begin
            w_cursor_nxt = (w_col == 4'd4) ? (r_cursor - 4'd4) : (r_cursor + 4'd1);
          end
        end
      end
      default: w_state_nxt = ST_MENU;
    endcase

    // Evaluated on next-state values so win lines up with the status it describes.
    w_win_nxt = (w_state_nxt == ST_GAME) && (w_status_nxt == 40'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_MENU;
      r_btn_q  <= '0;
      r_sel    <= 3'd1;
      r_cursor <= 4'd0;
      r_status <= {10{INIT_DIGIT}};
      r_buzz   <= '0;
      r_moves  <= 8'd0;
      r_win    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_btn_q  <= btn;
      r_sel    <= w_sel_nxt;
      r_cursor <= w_cursor_nxt;
      r_status <= w_status_nxt;
      r_buzz   <= w_buzz_nxt;
      r_moves  <= w_moves_nxt;
      r_win    <= w_win_nxt;
    end
  end

  assign state    = r_state;
  assign sel_num  = r_sel;
  assign cursor   = r_cursor;
  assign status   = r_status;
  assign buzz_req = r_buzz;
  assign moves    = r_moves;
  assign win      = r_win;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed self-checking bench for game_ctrl
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] btn;
  logic [1:0]  state;
  logic [2:0]  sel_num;
  logic [3:0]  cursor;
  logic [39:0] status;
  logic [9:0]  buzz_req;
  logic [7:0]  moves;
  logic        win;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [15:0] K_INFO = 16'h8000, K_NEXT = 16'h4000, K_BACK = 16'h2000,
                          K_QUIT = 16'h1000, K_CNT = 16'h0800, K_CONF = 16'h0400,
                          K_UP = 16'h0004, K_DOWN = 16'h0040, K_LEFT = 16'h0080,
                          K_RIGHT = 16'h0020;

  game_ctrl #(.MAX_SEL(4), .INIT_DIGIT(4'd1)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .state(state), .sel_num(sel_num),
    .cursor(cursor), .status(status), .buzz_req(buzz_req), .moves(moves), .win(win)
  );

  always #5 clk = ~clk;

  // Key goes high for one edge, then low; returns at the negedge after the acting edge.
  task automatic press(input logic [15:0] m);
    @(negedge clk); btn = m;
    @(negedge clk); btn = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; btn = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (sel_num !== 3'd1) begin n_err++; $display("FAIL reset_sel: got %0d want 1", sel_num); end
    n_cmp++; if (cursor !== 4'd0) begin n_err++; $display("FAIL reset_cursor: got %0d want 0", cursor); end
    n_cmp++; if (status !== 40'h1111111111) begin n_err++; $display("FAIL reset_status: got %h want 1111111111", status); end
    n_cmp++; if (buzz_req !== 10'd0 || moves !== 8'd0 || win !== 1'b0) begin
      n_err++; $display("FAIL reset_misc: buzz %b moves %0d win %b want 0/0/0", buzz_req, moves, win); end
    rst_n = 1'b1;
  endtask

  task automatic test_menu_flow;
    press(K_INFO);
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL menu_to_info: got %0d want 1", state); end
    press(K_BACK);
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL info_to_menu: got %0d want 0", state); end
    press(K_NEXT);
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL menu_to_select: got %0d want 2", state); end
    n_cmp++; if (status !== 40'h1111111111) begin n_err++; $display("FAIL flow_status: got %h want 1111111111", status); end
    press(K_QUIT);
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL select_quit: got %0d want 0", state); end
    press(K_NEXT | K_INFO);
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL menu_priority: got %0d want 2", state); end
  endtask

  task automatic test_select_count;
    logic [2:0] exp_sel [5];
    exp_sel = '{3'd2, 3'd3, 3'd4, 3'd1, 3'd2};
    for (int i = 0; i < 5; i++) begin
      press(K_CNT);
      n_cmp++; if (sel_num !== exp_sel[i]) begin n_err++; $display("FAIL count_step%0d: got %0d want %0d", i, sel_num, exp_sel[i]); end
    end
    @(negedge clk); btn = K_CNT;
    repeat (20) @(negedge clk);
    btn = '0;
    @(negedge clk);
    n_cmp++; if (sel_num !== 3'd3) begin n_err++; $display("FAIL count_hold: got %0d want 3", sel_num); end
  endtask

  task automatic test_confirm_span;
    press(K_NEXT);
    n_cmp++; if (state !== 2'd3 || cursor !== 4'd0 || moves !== 8'd0) begin
      n_err++; $display("FAIL game_entry: state %0d cursor %0d moves %0d want 3/0/0", state, cursor, moves); end
    press(K_DOWN);
    n_cmp++; if (cursor !== 4'd5) begin n_err++; $display("FAIL move_down: got %0d want 5", cursor); end
    press(K_LEFT);
    n_cmp++; if (cursor !== 4'd9) begin n_err++; $display("FAIL left_wrap: got %0d want 9", cursor); end
    press(K_RIGHT);
    n_cmp++; if (cursor !== 4'd5) begin n_err++; $display("FAIL right_wrap: got %0d want 5", cursor); end
    press(K_LEFT); press(K_LEFT);
    n_cmp++; if (cursor !== 4'd8) begin n_err++; $display("FAIL cursor_8: got %0d want 8", cursor); end
    press(K_UP | K_DOWN | K_LEFT);
    n_cmp++; if (cursor !== 4'd3) begin n_err++; $display("FAIL move_priority: got %0d want 3", cursor); end
    press(K_DOWN);
    press(K_CONF);
    n_cmp++; if (status !== 40'h2211111112) begin n_err++; $display("FAIL span_status: got %h want 2211111112", status); end
    n_cmp++; if (moves !== 8'd1 || buzz_req !== 10'd0) begin
      n_err++; $display("FAIL span_moves: moves %0d buzz %b want 1/0", moves, buzz_req); end
  endtask

  task automatic test_wrap_buzz;
    press(K_QUIT);
    n_cmp++; if (state !== 2'd0 || status !== 40'h2211111112 || moves !== 8'd1) begin
      n_err++; $display("FAIL quit_retain: state %0d status %h moves %0d want 0/2211111112/1", state, status, moves); end
    press(K_NEXT); press(K_CNT); press(K_CNT);
    n_cmp++; if (sel_num !== 3'd1) begin n_err++; $display("FAIL sel_back_to_1: got %0d want 1", sel_num); end
    press(K_NEXT);
    n_cmp++; if (status !== 40'h1111111111) begin n_err++; $display("FAIL reentry_status: got %h want 1111111111", status); end
    for (int i = 0; i < 8; i++) begin
      press(K_CONF);
      n_cmp++; if (status[3:0] !== 4'(i + 2) || buzz_req !== 10'd0) begin
        n_err++; $display("FAIL inc_%0d: digit0 %0d buzz %b want %0d/0", i, status[3:0], buzz_req, i + 2); end
    end
    press(K_CONF);
    n_cmp++; if (buzz_req !== 10'b0000000001) begin n_err++; $display("FAIL buzz_pulse: got %b want 0000000001", buzz_req); end
    n_cmp++; if (status !== 40'h1111111110 || moves !== 8'd9) begin
      n_err++; $display("FAIL wrap_status: status %h moves %0d want 1111111110/9", status, moves); end
    @(negedge clk);
    n_cmp++; if (buzz_req !== 10'd0) begin n_err++; $display("FAIL buzz_clear: got %b want 0", buzz_req); end
  endtask

  task automatic test_win;
    logic [15:0] step [9];
    step = '{K_RIGHT, K_RIGHT, K_RIGHT, K_RIGHT, K_DOWN, K_LEFT, K_LEFT, K_LEFT, K_LEFT};
    for (int s = 0; s < 9; s++) begin
      press(step[s]);
      repeat (9) press(K_CONF);
    end
    @(negedge clk);
    n_cmp++; if (status !== 40'd0 || cursor !== 4'd5 || moves !== 8'd90) begin
      n_err++; $display("FAIL win_setup: status %h cursor %0d moves %0d want 0/5/90", status, cursor, moves); end
    n_cmp++; if (win !== 1'b1) begin n_err++; $display("FAIL win_high: got %b want 1", win); end
    press(K_CONF); press(K_RIGHT);
    n_cmp++; if (moves !== 8'd90 || status !== 40'd0 || cursor !== 4'd5) begin
      n_err++; $display("FAIL win_frozen: moves %0d status %h cursor %0d want 90/0/5", moves, status, cursor); end
    press(K_QUIT);
    @(negedge clk);
    n_cmp++; if (state !== 2'd0 || win !== 1'b0 || moves !== 8'd90) begin
      n_err++; $display("FAIL win_quit: state %0d win %b moves %0d want 0/0/90", state, win, moves); end
  endtask

  task automatic test_reset_mid_game;
    press(K_NEXT); press(K_NEXT);
    @(negedge clk); btn = K_CONF;
    @(negedge clk);
    n_cmp++; if (state !== 2'd3 || moves !== 8'd1 || status !== 40'h1111111112) begin
      n_err++; $display("FAIL pre_reset: state %0d moves %0d status %h want 3/1/1111111112", state, moves, status); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (state !== 2'd0 || sel_num !== 3'd1 || cursor !== 4'd0 || status !== 40'h1111111111 ||
                 buzz_req !== 10'd0 || moves !== 8'd0 || win !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: state %0d sel %0d cur %0d status %h moves %0d want reset values",
                        state, sel_num, cursor, status, moves); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (state !== 2'd0 || status !== 40'h1111111111 || moves !== 8'd0) begin
      n_err++; $display("FAIL post_reset_hold: state %0d status %h moves %0d want 0/1111111111/0", state, status, moves); end
    btn = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = '0;
    test_reset;
    test_menu_flow;
    test_select_count;
    test_confirm_span;
    test_wrap_buzz;
    test_win;
    test_reset_mid_game;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
